// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_AW    = 5;
    localparam int CNT_W         = 5;
    localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WB   = 2'b10
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/busy/done handshake plus register-file write-back port.
interface muldiv_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [AW-1:0]    dest;
    logic             busy;
    logic             done;
    logic             wb_we;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output start, op, src_a, src_b, dest,
        input  busy, done, wb_we, wb_addr, wb_data
    );

    modport slave (
        input  start, op, src_a, src_b, dest,
        output busy, done, wb_we, wb_addr, wb_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU: 32 iterations, then a one-cycle
// register-file write-back. One accumulator/operand pair serves both paths.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);

    state_e             state;
    op_e                op_r;
    logic [CNT_W-1:0]   cnt;
    logic [AW-1:0]      dest_r;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               done_r;
    logic               wb_we_r;
    logic [AW-1:0]      wb_addr_r;
    logic [WIDTH-1:0]   wb_data_r;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   div_sub;
    logic               div_borrow;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   result_next;
    logic [1:0]         unused_sub_top;

    // Multiply keeps the multiplier in the low half and shifts the product in
    // from the top; divide keeps {remainder, quotient} and shifts left.
    always_comb begin
        mul_sum        = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        rem_shift      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_sub        = {1'b0, rem_shift} - {2'b00, opnd};
        div_borrow     = div_sub[WIDTH+1];
        unused_sub_top = div_sub[WIDTH+1:WIDTH];
        acc_next       = acc;
        if (is_div(op_r)) begin
            if (div_borrow)
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {div_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            if (acc[0])
                acc_next = {mul_sum, acc[WIDTH-1:1]};
            else
                acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
        case (op_r)
            OP_MUL,  OP_DIVU: result_next = acc_next[WIDTH-1:0];
            default:          result_next = acc_next[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_r      <= OP_MUL;
            cnt       <= '0;
            dest_r    <= '0;
            acc       <= '0;
            opnd      <= '0;
            done_r    <= 1'b0;
            wb_we_r   <= 1'b0;
            wb_addr_r <= '0;
            wb_data_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_r   <= op_e'(bus.op);
                        dest_r <= bus.dest;
                        cnt    <= '0;
                        if (is_div(op_e'(bus.op))) begin
                            opnd <= bus.src_b;
                            acc  <= {{WIDTH{1'b0}}, bus.src_a};
                        end else begin
                            opnd <= bus.src_a;
                            acc  <= {{WIDTH{1'b0}}, bus.src_b};
                        end
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == ITER_LAST) begin
                        done_r    <= 1'b1;
                        wb_we_r   <= (dest_r != '0);
                        wb_addr_r <= dest_r;
                        wb_data_r <= result_next;
                        state     <= WB;
                    end
                end
                WB: begin
                    done_r    <= 1'b0;
                    wb_we_r   <= 1'b0;
                    wb_addr_r <= '0;
                    wb_data_r <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.wb_we   = wb_we_r;
    assign bus.wb_addr = wb_addr_r;
    assign bus.wb_data = wb_data_r;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit. It sits between the register-file read ports and the register-file write port. It takes two 32-bit operands read from the register file, computes one of four results over 32 cycles, then issues a single-cycle write-back (write enable, destination address, data) to the register file. A start/busy/done handshake lets the control unit stall while the unit runs.

## Interface

Parameters:
- WIDTH, 32, operand and result width
- AW, 5, register address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- op  in  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder)
- src_a  in  WIDTH  operand A (RD1); multiplicand or dividend
- src_b  in  WIDTH  operand B (RD2); multiplier or divisor
- dest  in  AW  destination register address (A3)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse in the WB state
- wb_we  out  1  register-file write enable (WE_Reg)
- wb_addr  out  AW  register-file write address
- wb_data  out  WIDTH  register-file write data (WD_Reg)

## Operation

- States: IDLE, RUN, WB. Reset state is IDLE.
- IDLE:
  - On start=1, latch op, src_a, src_b and dest.
  - Clear the iteration counter and go to RUN.
  - While in IDLE, start=0 does nothing.
- RUN: one iteration per cycle, counter 0..31. After iteration 31, go to WB.
  - Multiply: shift-add into a 2·WIDTH accumulator. The product is exact modulo 2^64. MUL returns bits [31:0]; MULHU returns bits [63:32].
  - Divide: restoring algorithm on a 2·WIDTH {remainder, quotient} register. Remainder is WIDTH+1 bits internally to hold the subtract borrow.
- Divide by zero needs no special path:
  - quotient = 0xFFFFFFFF
  - remainder = src_a
- WB: lasts one cycle, then always returns to IDLE.
  - done=1, wb_addr=dest, wb_data=result.
  - wb_we=1 only when dest≠0. When dest=0, done still pulses and wb_data is still driven.
- start while busy (RUN or WB) is ignored. It is not queued. The latched operands must not change.
- Operand inputs are don't-care outside the start cycle.
- Reset at any time, including mid-RUN or in WB:
  - Abort immediately to IDLE.
  - No write-back is issued.
- Reset values: busy=0, done=0, wb_we=0, wb_addr=0, wb_data=0, internal registers 0.
- Outside WB: wb_we=0, done=0, wb_addr=0, wb_data=0.

## Timing

- Cycle 0: start sampled high in IDLE at the rising edge.
- Cycles 1–32: RUN, busy=1.
- Cycle 33: WB. busy=1, done=1, wb_we=1 (when dest≠0). The register file captures the write at the end of cycle 33.
- Cycle 34: IDLE. busy=0, and a new start is accepted in this cycle.
- Throughput: one operation per 34 cycles.
- All outputs are registered or decoded from state. There is no combinational path from inputs to outputs.

## Structure

- Shared package muldiv_pkg holds:
  - op encodings (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU)
  - state enum (IDLE, RUN, WB)
  - WIDTH/AW defaults
  - ITER_LAST = 31
- Single module; no sub-module.
- One datapath register set is shared between the multiply and divide paths and selected by the latched op.

## Test plan

- MUL: start, src_a=7, src_b=6, dest=3.
  - Required: busy high in cycles 1–33.
  - Required in cycle 33: wb_we=1, wb_addr=3, wb_data=42.
- MULHU: src_a=0xFFFFFFFF, src_b=0xFFFFFFFF, dest=5.
  - Required: wb_data=0xFFFFFFFE.
  - Repeat with MUL. Required: wb_data=0x00000001.
- DIVU then REMU: src_a=100, src_b=7.
  - Required: wb_data=14 and 2 respectively.
- Divide by zero: src_a=0x1234, src_b=0.
  - Required: DIVU gives 0xFFFFFFFF; REMU gives 0x1234.
- start pulsed at cycle 10 of a MUL with different operands.
  - Required: ignored; the original result is written at cycle 33.
  - Required: a new start at cycle 34 is accepted.
- rst asserted asynchronously at cycle 15 of a DIVU.
  - Required: outputs immediately 0, state IDLE, no wb_we pulse.
  - dest=0 case: MUL with dest=0. Required: done=1 and wb_we=0 in cycle 33.
